corner_finder: RTL

CORNER_FINDER -- requirements
Module: corner_finder

---
 rtl/corner_finder_pkg.sv | 21 ++
 rtl/corner_finder_delay.sv | 36 +++
 rtl/corner_finder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/corner_finder_pkg.sv
// rtl/corner_finder_pkg.sv - shared types and constants for the corner finder
// Holds the FSM state encoding, the corner index constants (TL, TR, BL, BR)
// and the coordinate / metric / hit-counter widths used by the design.
package corner_finder_pkg;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      SCAN      = 2'd1,
      PUBLISH   = 2'd2
   } state_t;

   localparam int TL = 0;
   localparam int TR = 1;
   localparam int BL = 2;
   localparam int BR = 3;

   localparam int COORD_W  = 11;
   localparam int METRIC_W = 12;
   localparam int HITS_W   = 19;

endpackage

// File: rtl/corner_finder_delay.sv
// rtl/corner_finder_delay.sv - generic register delay line
// Ports: clk, reset (sync active-high), data_in [DATA_WIDTH], data_out [DATA_WIDTH].
// data_out is data_in delayed by DELAY clock cycles; reset clears every stage.
module corner_finder_delay
   import corner_finder_pkg::*;
#(
   parameter int DATA_WIDTH = 23,
   parameter int DELAY      = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DELAY-1:0][DATA_WIDTH-1:0] pipe_q, pipe_d;

   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = data_in;
      for (int i = 1; i < DELAY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign data_out = pipe_q[DELAY-1];

endmodule

// File: rtl/corner_finder.sv
// rtl/corner_finder.sv - tracks the four extreme marker pixels of each video frame
// Ports: clk, reset (sync active-high); VGA_X/VGA_Y [11] pixel position;
// pixel_hit marker match; eight 11-bit corner coordinate outputs;
// corners_valid (published set had >= p_min_hits hits); frame_done (1-cycle pulse).
module corner_finder
   import corner_finder_pkg::*;
#(
   parameter int p_screen_width  = 640,
   parameter int p_screen_height = 480,
   parameter int p_min_hits      = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [10:0]  VGA_X,
   input  logic [10:0]  VGA_Y,
   input  logic         pixel_hit,
   output logic [10:0]  top_left_x,
   output logic [10:0]  top_left_y,
   output logic [10:0]  top_right_x,
   output logic [10:0]  top_right_y,
   output logic [10:0]  bot_left_x,
   output logic [10:0]  bot_left_y,
   output logic [10:0]  bot_right_x,
   output logic [10:0]  bot_right_y,
   output logic         corners_valid,
   output logic         frame_done
);

   localparam logic [COORD_W-1:0] SCREEN_W = COORD_W'(p_screen_width);
   localparam logic [COORD_W-1:0] SCREEN_H = COORD_W'(p_screen_height);
   localparam logic [COORD_W-1:0] LAST_X   = COORD_W'(p_screen_width - 1);
   localparam logic [COORD_W-1:0] LAST_Y   = COORD_W'(p_screen_height - 1);
   localparam logic [HITS_W-1:0]  MIN_HITS = HITS_W'(p_min_hits);

   // Stage 0: registered pixel {x, y, hit}
   logic [22:0]        s0_bus;
   logic [COORD_W-1:0] s0_x, s0_y;
   logic               s0_hit;

   corner_finder_delay #(.DATA_WIDTH(23), .DELAY(1)) u_stage0 (
      .clk      (clk),
      .reset    (reset),
      .data_in  ({VGA_X, VGA_Y, pixel_hit}),
      .data_out (s0_bus)
   );

   assign s0_x   = s0_bus[22:12];
   assign s0_y   = s0_bus[11:1];
   assign s0_hit = s0_bus[0];

   // The cleared stage-0 register reads as pixel (0,0); this flag keeps that
   // reset image from being taken as a real frame start.
   logic s0_vld_q, s0_vld_d;

   state_t                       state_q, state_d;
   logic [HITS_W-1:0]            hits_q, hits_d;
   logic                         any_q, any_d;
   logic [3:0][COORD_W-1:0]      acc_x_q, acc_x_d, acc_y_q, acc_y_d;
   logic [3:0][METRIC_W-1:0]     metric_q, metric_d;
   logic [3:0][COORD_W-1:0]      out_x_q, out_x_d, out_y_q, out_y_d;
   logic                         valid_q, valid_d;
   logic                         frame_done_q, frame_done_d;

   logic                     hit, is_origin, is_last, first;
   logic [HITS_W-1:0]        hits_base;
   logic [METRIC_W-1:0]      sum, diff;
   logic [3:0][METRIC_W-1:0] cand;
   logic [3:0]               better;

   always_comb begin
      s0_vld_d  = 1'b1;
      hit       = s0_vld_q && s0_hit && (s0_x < SCREEN_W) && (s0_y < SCREEN_H);
      is_origin = s0_vld_q && (s0_x == '0) && (s0_y == '0);
      is_last   = s0_vld_q && (s0_x == LAST_X) && (s0_y == LAST_Y);

      // X+Y as 12-bit unsigned, X-Y as 12-bit two's complement
      sum  = METRIC_W'(s0_x) + METRIC_W'(s0_y);
      diff = METRIC_W'(s0_x) - METRIC_W'(s0_y);
      cand[TL] = sum;
      cand[BR] = sum;
      cand[TR] = diff;
      cand[BL] = diff;

      // Strict compares so a tie keeps the earlier pixel
      better[TL] = sum < metric_q[TL];
      better[BR] = sum > metric_q[BR];
      better[TR] = $signed(diff) > $signed(metric_q[TR]);
      better[BL] = $signed(diff) < $signed(metric_q[BL]);

      // (0,0) restarts the frame and is itself its first pixel
      hits_base = is_origin ? '0 : hits_q;
      first     = is_origin || !any_q;

      hits_d   = hits_base;
      any_d    = any_q && !is_origin;
      acc_x_d  = acc_x_q;
      acc_y_d  = acc_y_q;
      metric_d = metric_q;
      if (hit) begin
         any_d = 1'b1;
         if (hits_base != '1) begin
            hits_d = hits_base + HITS_W'(1);
         end
         for (int k = 0; k < 4; k++) begin
            if (first || better[k]) begin
               acc_x_d[k]  = s0_x;
               acc_y_d[k]  = s0_y;
               metric_d[k] = cand[k];
            end
         end
      end

      state_d      = state_q;
      out_x_d      = out_x_q;
      out_y_d      = out_y_q;
      valid_d      = valid_q;
      frame_done_d = 1'b0;
      case (state_q)
         WAIT_SYNC: if (is_origin) state_d = SCAN;
         SCAN:      if (is_last)   state_d = PUBLISH;
         PUBLISH: begin
            // Reads the _q accumulators, so a (0,0) landing on this same
            // edge cannot disturb the frame being published.
            state_d      = SCAN;
            frame_done_d = 1'b1;
            if (hits_q >= MIN_HITS) begin
               out_x_d = acc_x_q;
               out_y_d = acc_y_q;
               valid_d = 1'b1;
            end else begin
               valid_d = 1'b0;
            end
         end
         default:   state_d = WAIT_SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s0_vld_q     <= 1'b0;
         state_q      <= WAIT_SYNC;
         hits_q       <= '0;
         any_q        <= 1'b0;
         acc_x_q      <= '0;
         acc_y_q      <= '0;
         metric_q     <= '0;
         out_x_q      <= '0;
         out_y_q      <= '0;
         valid_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         s0_vld_q     <= s0_vld_d;
         state_q      <= state_d;
         hits_q       <= hits_d;
         any_q        <= any_d;
         acc_x_q      <= acc_x_d;
         acc_y_q      <= acc_y_d;
         metric_q     <= metric_d;
         out_x_q      <= out_x_d;
         out_y_q      <= out_y_d;
         valid_q      <= valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign top_left_x    = out_x_q[TL];
   assign top_left_y    = out_y_q[TL];
   assign top_right_x   = out_x_q[TR];
   assign top_right_y   = out_y_q[TR];
   assign bot_left_x    = out_x_q[BL];
   assign bot_left_y    = out_y_q[BL];
   assign bot_right_x   = out_x_q[BR];
   assign bot_right_y   = out_y_q[BR];
   assign corners_valid = valid_q;
   assign frame_done    = frame_done_q;

endmodule
